// File: rtl/ram_sp_be_init_if.sv
// Access bus for the single-port byte-enable RAM.
// The master drives requests and the clear command.
// The slave returns read data, the read strobe and readiness.
interface ram_sp_be_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  clr;
  logic                  req;
  logic                  we;
  logic [NBYTES-1:0]     be;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  ready;

  modport master (
    output clr,
    output req,
    output we,
    output be,
    output address,
    output d,
    input  q,
    input  q_valid,
    input  ready
  );

  modport slave (
    input  clr,
    input  req,
    input  we,
    input  be,
    input  address,
    input  d,
    output q,
    output q_valid,
    output ready
  );
endinterface

// File: rtl/ram_sp_be_init.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// After reset, and on a clear request, a hardware sweep zero-fills every word.
// Accesses are accepted only while ready is high, which means the FSM is in IDLE.
module ram_sp_be_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_sp_be_init_if.slave  bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  ready_reg;
  logic                  q_valid_reg;

  // Decoded access controls shared by the FSM and the byte lanes.
  logic                  in_init;
  logic                  take_clr;
  logic                  acc_write;
  logic                  acc_read;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     lane_we;
  logic [DATA_WIDTH-1:0] q_word;

  // Decode the current cycle: a sweep write, or a user access in IDLE.
  // A clear in IDLE wins over any same-cycle request, which is then dropped.
  always_comb begin
    in_init   = (state_reg == ST_INIT);
    take_clr  = !in_init && bus.clr;
    acc_write = !in_init && !bus.clr && bus.req && bus.we;
    acc_read  = !in_init && !bus.clr && bus.req && !bus.we;
    wr_addr   = bus.address;
    wr_data   = bus.d;
    lane_we   = '0;
    if (in_init) begin
      // The sweep writes a full zero word at the counter address.
      wr_addr = cnt_reg;
      wr_data = '0;
      lane_we = '1;
    end else if (acc_write) begin
      lane_we = bus.be;
    end
  end

  // Control FSM: sweep counter, readiness and the one-cycle read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_INIT;
      cnt_reg     <= '0;
      ready_reg   <= 1'b0;
      q_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          q_valid_reg <= 1'b0;
          cnt_reg     <= cnt_reg + 1'b1;
          // The edge that clears the last word also opens the RAM for use.
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (take_clr) begin
            state_reg   <= ST_INIT;
            cnt_reg     <= '0;
            ready_reg   <= 1'b0;
            q_valid_reg <= 1'b0;
          end else begin
            q_valid_reg <= acc_read;
          end
        end
        default: begin
          state_reg   <= ST_INIT;
          cnt_reg     <= '0;
          ready_reg   <= 1'b0;
          q_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // One narrow memory per byte lane keeps the byte enables a plain write enable.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] q_byte;

    // Lane write port: no reset, the sweep is what makes the contents known.
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        lane_mem[wr_addr] <= wr_data[8*gi +: 8];
      end
    end

    // Lane read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_byte <= 8'h00;
      end else if (acc_read) begin
        q_byte <= lane_mem[bus.address];
      end
    end

    assign q_word[8*gi +: 8] = q_byte;
  end

  assign bus.q       = q_word;
  assign bus.q_valid = q_valid_reg;
  assign bus.ready   = ready_reg;
endmodule

// File: tb/tb_ram_sp_be_init.sv
// Directed bench for ram_sp_be_init.
// A reference model of the memory runs alongside and is compared every cycle;
// literal expectations at key points pin the model itself.
module tb_ram_sp_be_init;
  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_sp_be_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_sp_be_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: remaining sweep edges, memory image and expected outputs.
  int          remain = DEPTH;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q  = 32'h0;
  logic        exp_qv = 1'b0;
  logic        exp_ready;

  assign exp_ready = (remain == 0);

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  en);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Model update: a sweep leaves the whole memory zero before ready returns.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= DEPTH;
      exp_q  <= 32'h0;
      exp_qv <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] <= 32'h0;
    end else if (remain != 0) begin
      remain <= remain - 1;
      exp_qv <= 1'b0;
    end else if (bus.clr) begin
      remain <= DEPTH;
      exp_qv <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] <= 32'h0;
    end else if (bus.req && bus.we) begin
      mem_m[bus.address] <= merge(mem_m[bus.address], bus.d, bus.be);
      exp_qv <= 1'b0;
    end else if (bus.req) begin
      exp_q  <= mem_m[bus.address];
      exp_qv <= 1'b1;
    end else begin
      exp_qv <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready",   {31'b0, bus.ready},   {31'b0, exp_ready});
      check("model_q_valid", {31'b0, bus.q_valid}, {31'b0, exp_qv});
      check("model_q",       bus.q,                exp_q);
    end
  end

  task automatic idle_bus();
    bus.clr = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    bus.be = 4'h0; bus.address = '0; bus.d = 32'h0;
  endtask

  // Counts edges until ready is seen, optionally pulsing read requests meanwhile.
  task automatic wait_ready(input string name, input bit pulse_req, input int exp_edges);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 300 && !seen) begin
      if (pulse_req) begin
        bus.req = n[0]; bus.we = 1'b0; bus.address = AW'(n);
      end
      @(negedge clk);
      n++;
      if (bus.ready) seen = 1;
    end
    bus.req = 1'b0;
    check({name, "_ready_seen"}, {31'b0, seen}, 32'd1);
    check({name, "_edges"}, n, exp_edges);
  endtask

  task automatic do_write(input int a, input logic [31:0] dat, input logic [3:0] b);
    bus.req = 1'b1; bus.we = 1'b1; bus.address = AW'(a); bus.d = dat; bus.be = b;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0;
    $display("write addr=%0d d=%h be=%b", a, dat, b);
  endtask

  task automatic do_read(input string name, input int a, input logic [31:0] expv);
    bus.req = 1'b1; bus.we = 1'b0; bus.address = AW'(a); bus.be = 4'h0;
    @(negedge clk);
    bus.req = 1'b0;
    check({name, "_q"}, bus.q, expv);
    check({name, "_valid"}, {31'b0, bus.q_valid}, 32'd1);
    $display("read  addr=%0d q=%h q_valid=%b", a, bus.q, bus.q_valid);
  endtask

  initial begin
    idle_bus();
    // Test 1: reset, full sweep, then every word reads zero.
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready",   {31'b0, bus.ready},   32'd0);
    check("reset_q_valid", {31'b0, bus.q_valid}, 32'd0);
    check("reset_q",       bus.q,                32'd0);
    #2 rst_n = 1'b1;
    wait_ready("t1", 1'b0, 128);
    for (int i = 0; i < DEPTH; i++) do_read("t1_zero", i, 32'h0);
    @(negedge clk);
    check("t1_valid_drops", {31'b0, bus.q_valid}, 32'd0);

    // Test 2: full-word write and read, neighbours untouched.
    do_write(5, 32'hDEADBEEF, 4'hF);
    do_read("t2_a5", 5, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_pulse", {31'b0, bus.q_valid}, 32'd0);
    check("t2_hold_q", bus.q, 32'hDEADBEEF);
    do_read("t2_a4", 4, 32'h0);
    do_read("t2_a6", 6, 32'h0);

    // Test 3: partial byte write, then an all-disabled write.
    do_write(5, 32'h11223344, 4'b0101);
    do_read("t3_merge", 5, 32'hDE22BE44);
    do_write(5, 32'hFFFFFFFF, 4'h0);
    do_read("t3_be0", 5, 32'hDE22BE44);

    // Test 4: clear with a same-cycle write; reads during the sweep are ignored.
    do_write(9, 32'hCAFEF00D, 4'hF);
    bus.clr = 1'b1; bus.req = 1'b1; bus.we = 1'b1;
    bus.address = AW'(9); bus.d = 32'h12345678; bus.be = 4'hF;
    @(negedge clk);
    idle_bus();
    check("t4_ready_low", {31'b0, bus.ready}, 32'd0);
    wait_ready("t4", 1'b1, 128);
    do_read("t4_a5", 5, 32'h0);
    do_read("t4_a9", 9, 32'h0);

    // Test 5: reset in the middle of a sweep restarts it from zero.
    do_write(5, 32'h87654321, 4'hF);
    do_read("t5_pre", 5, 32'h87654321);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_ready", {31'b0, bus.ready}, 32'd0);
    check("t5_rst_q",     bus.q,              32'd0);
    #2 rst_n = 1'b1;
    wait_ready("t5", 1'b0, 128);
    do_read("t5_a5", 5, 32'h0);
    do_read("t5_a127", 127, 32'h0);

    // Test 6: extreme addresses, back-to-back reads.
    do_write(127, 32'hA5A5A5A5, 4'hF);
    do_write(0, 32'h5A5A5A5A, 4'hF);
    do_read("t6_r0", 127, 32'hA5A5A5A5);
    do_read("t6_r1", 0,   32'h5A5A5A5A);
    do_read("t6_r2", 127, 32'hA5A5A5A5);
    @(negedge clk);
    check("t6_hold_q", bus.q, 32'hA5A5A5A5);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
